// File: rtl/aclk_pkg.sv
// Shared alarm-clock types and constants: BCD digits, hh:mm time record,
// and the time validity check also used by the clock-set logic.
package aclk_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t ms_hr;
    bcd_t ls_hr;
    bcd_t ms_min;
    bcd_t ls_min;
  } bcd_time_t;

  localparam int MAX_HR     = 23;
  localparam int MAX_MIN    = 59;
  localparam int MIN_PER_HR = 60;

  // Every digit must be decimal before the hour/minute ranges mean anything.
  function automatic logic time_valid(input bcd_time_t t);
    int hr;
    int mn;
    hr = 10 * int'(t.ms_hr) + int'(t.ls_hr);
    mn = 10 * int'(t.ms_min) + int'(t.ls_min);
    return (t.ms_hr <= 4'd9) && (t.ls_hr <= 4'd9) &&
           (t.ms_min <= 4'd9) && (t.ls_min <= 4'd9) &&
           (hr <= MAX_HR) && (mn <= MAX_MIN);
  endfunction

endpackage

// File: rtl/aclk_areg_bank_if.sv
// Bus between the key/load logic (master) and the alarm register bank (slave).
interface aclk_areg_bank_if #(
  parameter int NUM_ALARMS = 4
);
  import aclk_pkg::*;

  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  load_new_a;
  logic [IDX_W-1:0]      load_idx;
  bcd_t                  new_alarm_ms_hr;
  bcd_t                  new_alarm_ls_hr;
  bcd_t                  new_alarm_ms_min;
  bcd_t                  new_alarm_ls_min;
  logic                  new_arm;
  bcd_t                  current_time_ms_hr;
  bcd_t                  current_time_ls_hr;
  bcd_t                  current_time_ms_min;
  bcd_t                  current_time_ls_min;
  logic                  snooze;
  logic                  stop_alarm;
  logic [IDX_W-1:0]      rd_idx;
  bcd_t                  alarm_time_ms_hr;
  bcd_t                  alarm_time_ls_hr;
  bcd_t                  alarm_time_ms_min;
  bcd_t                  alarm_time_ls_min;
  logic                  alarm_armed;
  logic [NUM_ALARMS-1:0] alarm_pending;
  logic                  sound_alarm;
  logic                  load_err;

  modport master (
    output load_new_a, load_idx,
    output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min, new_arm,
    output current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
    output snooze, stop_alarm, rd_idx,
    input  alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
    input  alarm_armed, alarm_pending, sound_alarm, load_err
  );

  modport slave (
    input  load_new_a, load_idx,
    input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min, new_arm,
    input  current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
    input  snooze, stop_alarm, rd_idx,
    output alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
    output alarm_armed, alarm_pending, sound_alarm, load_err
  );

endinterface

// File: rtl/aclk_bcd_add_min.sv
// Combinational BCD hh:mm plus a constant number of minutes, wrapping at
// the hour and at midnight. The input is assumed to be a valid time.
module aclk_bcd_add_min
  import aclk_pkg::*;
#(
  parameter int ADD_MIN = 5
) (
  input  bcd_time_t i_time,
  output bcd_time_t o_time
);

  logic [6:0] w_min_in;
  logic [6:0] w_min_sum;
  logic [6:0] w_min_out;
  logic       w_carry;
  logic [4:0] w_hr_in;
  logic [4:0] w_hr_inc;
  logic [4:0] w_hr_out;

  // ADD_MIN <= 59, so a single subtract of 60 always brings minutes back in range.
  assign w_min_in  = 7'(i_time.ms_min) * 7'd10 + 7'(i_time.ls_min);
  assign w_min_sum = w_min_in + 7'(ADD_MIN);
  assign w_carry   = (w_min_sum >= 7'(MIN_PER_HR));
  assign w_min_out = w_carry ? (w_min_sum - 7'(MIN_PER_HR)) : w_min_sum;

  assign w_hr_in  = 5'(i_time.ms_hr) * 5'd10 + 5'(i_time.ls_hr);
  assign w_hr_inc = w_hr_in + 5'(w_carry);
  assign w_hr_out = (w_hr_inc > 5'(MAX_HR)) ? 5'd0 : w_hr_inc;

  assign o_time.ms_hr  = 4'(w_hr_out / 5'd10);
  assign o_time.ls_hr  = 4'(w_hr_out % 5'd10);
  assign o_time.ms_min = 4'(w_min_out / 7'd10);
  assign o_time.ls_min = 4'(w_min_out % 7'd10);

endmodule

// File: rtl/aclk_areg_bank.sv
// Alarm register bank: NUM_ALARMS BCD alarm slots with arm bits, rising-match
// pending flags, snooze/stop handling and a registered readback port.
module aclk_areg_bank
  import aclk_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5
) (
  input logic               clk,
  input logic               reset,
  aclk_areg_bank_if.slave   bus
);

  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  bcd_time_t             r_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_arm;
  logic [NUM_ALARMS-1:0] r_pending;
  logic [NUM_ALARMS-1:0] r_prev_match;
  bcd_time_t             r_rd_time;
  logic                  r_rd_arm;
  logic                  r_sound;
  logic                  r_load_err;

  bcd_time_t             w_cur;
  bcd_time_t             w_new;
  logic                  w_new_valid;
  logic                  w_load_reject;
  bcd_time_t             w_snz_time  [NUM_ALARMS];
  bcd_time_t             w_time_next [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] w_match;
  logic [NUM_ALARMS-1:0] w_rise;
  logic [NUM_ALARMS-1:0] w_idx_hit;
  logic [NUM_ALARMS-1:0] w_load_hit;
  logic [NUM_ALARMS-1:0] w_pend_next;
  logic [NUM_ALARMS-1:0] w_arm_next;
  bcd_time_t             w_rd_time;
  logic                  w_rd_arm;

  assign w_cur = '{ms_hr:  bus.current_time_ms_hr,  ls_hr:  bus.current_time_ls_hr,
                   ms_min: bus.current_time_ms_min, ls_min: bus.current_time_ls_min};
  assign w_new = '{ms_hr:  bus.new_alarm_ms_hr,  ls_hr:  bus.new_alarm_ls_hr,
                   ms_min: bus.new_alarm_ms_min, ls_min: bus.new_alarm_ls_min};

  assign w_new_valid   = time_valid(w_new);
  // An index that hits no slot is out of range and rejects the load.
  assign w_load_reject = bus.load_new_a && !(w_new_valid && (|w_idx_hit));

  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
    aclk_bcd_add_min #(
      .ADD_MIN (SNOOZE_MIN)
    ) u_snooze_add (
      .i_time (r_time[gi]),
      .o_time (w_snz_time[gi])
    );

    assign w_match[gi]    = r_arm[gi] && (r_time[gi] == w_cur);
    assign w_rise[gi]     = w_match[gi] && !r_prev_match[gi];
    assign w_idx_hit[gi]  = (bus.load_idx == IDX_W'(gi));
    assign w_load_hit[gi] = bus.load_new_a && w_new_valid && w_idx_hit[gi];

    // Load beats everything; a fresh match beats stop/snooze so an alarm is never lost.
    assign w_pend_next[gi] = w_load_hit[gi] ? 1'b0 :
                             w_rise[gi]     ? 1'b1 :
                             (bus.stop_alarm || bus.snooze) ? 1'b0 : r_pending[gi];

    // Stop outranks snooze, so only advance when snooze arrives alone.
    assign w_time_next[gi] = w_load_hit[gi] ? w_new :
                             (bus.snooze && !bus.stop_alarm && r_pending[gi]) ?
                             w_snz_time[gi] : r_time[gi];

    assign w_arm_next[gi] = w_load_hit[gi] ? bus.new_arm : r_arm[gi];
  end

  always_comb begin
    w_rd_time = '0;
    w_rd_arm  = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (bus.rd_idx == IDX_W'(i)) begin
        w_rd_time = r_time[i];
        w_rd_arm  = r_arm[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_time[i] <= '0;
      end
      r_arm        <= '0;
      r_pending    <= '0;
      r_prev_match <= '0;
      r_rd_time    <= '0;
      r_rd_arm     <= 1'b0;
      r_sound      <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_time[i] <= w_time_next[i];
      end
      r_arm        <= w_arm_next;
      r_pending    <= w_pend_next;
      r_prev_match <= w_match;
      r_rd_time    <= w_rd_time;
      r_rd_arm     <= w_rd_arm;
      r_sound      <= |r_pending;
      r_load_err   <= w_load_reject;
    end
  end

  assign bus.alarm_time_ms_hr  = r_rd_time.ms_hr;
  assign bus.alarm_time_ls_hr  = r_rd_time.ls_hr;
  assign bus.alarm_time_ms_min = r_rd_time.ms_min;
  assign bus.alarm_time_ls_min = r_rd_time.ls_min;
  assign bus.alarm_armed       = r_rd_arm;
  assign bus.alarm_pending     = r_pending;
  assign bus.sound_alarm       = r_sound;
  assign bus.load_err          = r_load_err;

endmodule
